recovery_phase_sequencer: RTL and testbench

//  Central recovery controller for the back end. Collects refetch/flush requests from the

---
 rtl/recovery_phase_sequencer.sv | 175 +++++++++++++++++
 tb/tb_recovery_phase_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/recovery_phase_sequencer.sv
// Back-end recovery controller: picks the oldest refetch/flush request, steps
// COMMIT -> RECOVER_0 -> RECOVER_1 -> COMMIT and drives the flush range and refetch PC.
module recovery_phase_sequencer #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned AL_W    = 6,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned DROP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*AL_W-1:0]   req_al_ptr,
  input  logic [NUM_REQ*3-1:0]      req_type,
  input  logic [NUM_REQ*PC_W-1:0]   req_pc,
  input  logic [NUM_REQ*PC_W-1:0]   req_target,
  input  logic [AL_W-1:0]           al_head_ptr,
  input  logic [AL_W-1:0]           al_tail_ptr,
  input  logic [PC_W-1:0]           csr_target,
  input  logic                      recovery_done,
  output logic [1:0]                phase,
  output logic                      flush_valid,
  output logic                      flush_all,
  output logic [AL_W-1:0]           flush_head,
  output logic [AL_W-1:0]           flush_tail,
  output logic                      refetch_valid,
  output logic [PC_W-1:0]           refetch_pc,
  output logic [AL_W-1:0]           recovery_al_ptr,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);
  localparam int unsigned SUM_W = DROP_W + CNT_W;
  localparam logic [1:0] PH_COMMIT    = 2'd0;
  localparam logic [1:0] PH_RECOVER_0 = 2'd1;
  localparam logic [1:0] PH_RECOVER_1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              flush_valid_q, flush_valid_d;
  logic              flush_all_q, flush_all_d;
  logic [AL_W-1:0]   flush_head_q, flush_head_d;
  logic [AL_W-1:0]   flush_tail_q, flush_tail_d;
  logic              refetch_valid_q, refetch_valid_d;
  logic [PC_W-1:0]   refetch_pc_q, refetch_pc_d;
  logic [AL_W-1:0]   recovery_al_ptr_q, recovery_al_ptr_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  logic              any_req_c;
  logic [AL_W-1:0]   win_ptr_c;
  logic [2:0]        win_type_c;
  logic [PC_W-1:0]   win_pc_c;
  logic [PC_W-1:0]   win_target_c;
  logic [AL_W-1:0]   best_age_c;
  logic [AL_W-1:0]   age_c;
  logic [CNT_W-1:0]  req_pop_c;
  logic [SUM_W-1:0]  drop_sum_c;

  // Oldest request by age relative to head; strict compare keeps the lowest port on ties.
  always_comb begin
    any_req_c    = 1'b0;
    win_ptr_c    = '0;
    win_type_c   = '0;
    win_pc_c     = '0;
    win_target_c = '0;
    best_age_c   = '0;
    age_c        = '0;
    req_pop_c    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      age_c     = AL_W'(req_al_ptr[i*AL_W +: AL_W] - al_head_ptr);
      req_pop_c = CNT_W'(req_pop_c + CNT_W'(req_valid[i]));
      if (req_valid[i] && (!any_req_c || (age_c < best_age_c))) begin
        any_req_c    = 1'b1;
        best_age_c   = age_c;
        win_ptr_c    = req_al_ptr[i*AL_W +: AL_W];
        win_type_c   = req_type[i*3 +: 3];
        win_pc_c     = req_pc[i*PC_W +: PC_W];
        win_target_c = req_target[i*PC_W +: PC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= PH_COMMIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_COMMIT:    if (any_req_c) state_d = PH_RECOVER_0;
      PH_RECOVER_0: state_d = PH_RECOVER_1;
      PH_RECOVER_1: if (recovery_done) state_d = PH_COMMIT;
      default:      state_d = PH_COMMIT;
    endcase
  end

  // Output decode; recovery outputs are computed in the accept cycle so they are valid in RECOVER_0.
  always_comb begin
    flush_valid_d     = flush_valid_q;
    flush_all_d       = flush_all_q;
    flush_head_d      = flush_head_q;
    flush_tail_d      = flush_tail_q;
    refetch_valid_d   = 1'b0;
    refetch_pc_d      = refetch_pc_q;
    recovery_al_ptr_d = recovery_al_ptr_q;
    drop_count_d      = drop_count_q;
    drop_sum_c        = SUM_W'(drop_count_q) + SUM_W'(req_pop_c);
    case (state_q)
      PH_COMMIT: begin
        if (any_req_c) begin
          refetch_valid_d   = 1'b1;
          flush_valid_d     = 1'b1;
          flush_tail_d      = al_tail_ptr;
          recovery_al_ptr_d = win_ptr_c;
          flush_all_d       = (win_type_c == 3'd4) || (win_type_c == 3'd5);
          case (win_type_c)
            3'd1, 3'd2: refetch_pc_d = PC_W'(win_pc_c + PC_W'(4));
            3'd3:       refetch_pc_d = win_target_c;
            3'd4, 3'd5: refetch_pc_d = csr_target;
            default:    refetch_pc_d = win_pc_c;
          endcase
          case (win_type_c)
            3'd1, 3'd2, 3'd3, 3'd4: flush_head_d = AL_W'(win_ptr_c + AL_W'(1));
            default:                flush_head_d = win_ptr_c;
          endcase
        end
      end
      PH_RECOVER_0, PH_RECOVER_1: begin
        if (drop_sum_c > SUM_W'({DROP_W{1'b1}})) drop_count_d = '1;
        else                                     drop_count_d = DROP_W'(drop_sum_c);
        if ((state_q == PH_RECOVER_1) && recovery_done) begin
          flush_valid_d     = 1'b0;
          flush_all_d       = 1'b0;
          flush_head_d      = '0;
          flush_tail_d      = '0;
          refetch_pc_d      = '0;
          recovery_al_ptr_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_valid_q     <= 1'b0;
      flush_all_q       <= 1'b0;
      flush_head_q      <= '0;
      flush_tail_q      <= '0;
      refetch_valid_q   <= 1'b0;
      refetch_pc_q      <= '0;
      recovery_al_ptr_q <= '0;
      drop_count_q      <= '0;
    end else begin
      flush_valid_q     <= flush_valid_d;
      flush_all_q       <= flush_all_d;
      flush_head_q      <= flush_head_d;
      flush_tail_q      <= flush_tail_d;
      refetch_valid_q   <= refetch_valid_d;
      refetch_pc_q      <= refetch_pc_d;
      recovery_al_ptr_q <= recovery_al_ptr_d;
      drop_count_q      <= drop_count_d;
    end
  end

  assign phase           = state_q;
  assign flush_valid     = flush_valid_q;
  assign flush_all       = flush_all_q;
  assign flush_head      = flush_head_q;
  assign flush_tail      = flush_tail_q;
  assign refetch_valid   = refetch_valid_q;
  assign refetch_pc      = refetch_pc_q;
  assign recovery_al_ptr = recovery_al_ptr_q;
  assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_recovery_phase_sequencer.sv
// Directed bench for recovery_phase_sequencer; a second instance with a 2-bit
// drop counter checks saturation under the same stimulus.
module tb_recovery_phase_sequencer;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned AL_W    = 6;
  localparam int unsigned PC_W    = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AL_W-1:0] req_al_ptr;
  logic [NUM_REQ*3-1:0]    req_type;
  logic [NUM_REQ*PC_W-1:0] req_pc;
  logic [NUM_REQ*PC_W-1:0] req_target;
  logic [AL_W-1:0]         al_head_ptr;
  logic [AL_W-1:0]         al_tail_ptr;
  logic [PC_W-1:0]         csr_target;
  logic                    recovery_done;
  logic [1:0]              phase, phase2;
  logic                    flush_valid, flush_all, refetch_valid;
  logic                    flush_valid2, flush_all2, refetch_valid2;
  logic [AL_W-1:0]         flush_head, flush_tail, recovery_al_ptr;
  logic [AL_W-1:0]         flush_head2, flush_tail2, recovery_al_ptr2;
  logic [PC_W-1:0]         refetch_pc, refetch_pc2;
  logic [7:0]              drop_count;
  logic [1:0]              drop_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  recovery_phase_sequencer #(.NUM_REQ(NUM_REQ), .AL_W(AL_W), .PC_W(PC_W), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_al_ptr(req_al_ptr),
    .req_type(req_type), .req_pc(req_pc), .req_target(req_target),
    .al_head_ptr(al_head_ptr), .al_tail_ptr(al_tail_ptr), .csr_target(csr_target),
    .recovery_done(recovery_done), .phase(phase), .flush_valid(flush_valid),
    .flush_all(flush_all), .flush_head(flush_head), .flush_tail(flush_tail),
    .refetch_valid(refetch_valid), .refetch_pc(refetch_pc),
    .recovery_al_ptr(recovery_al_ptr), .drop_count(drop_count));

  recovery_phase_sequencer #(.NUM_REQ(NUM_REQ), .AL_W(AL_W), .PC_W(PC_W), .DROP_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_al_ptr(req_al_ptr),
    .req_type(req_type), .req_pc(req_pc), .req_target(req_target),
    .al_head_ptr(al_head_ptr), .al_tail_ptr(al_tail_ptr), .csr_target(csr_target),
    .recovery_done(recovery_done), .phase(phase2), .flush_valid(flush_valid2),
    .flush_all(flush_all2), .flush_head(flush_head2), .flush_tail(flush_tail2),
    .refetch_valid(refetch_valid2), .refetch_pc(refetch_pc2),
    .recovery_al_ptr(recovery_al_ptr2), .drop_count(drop_count2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic [AL_W-1:0] ptr, input logic [2:0] typ,
                         input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
    req_valid[port]                = 1'b1;
    req_al_ptr[port*AL_W +: AL_W]  = ptr;
    req_type[port*3 +: 3]          = typ;
    req_pc[port*PC_W +: PC_W]      = pc;
    req_target[port*PC_W +: PC_W]  = tgt;
  endtask

  task automatic finish_recovery(input string tag);
    step();
    check_eq({tag, "_r1_phase"}, 32'(phase), 32'd2);
    recovery_done = 1'b1;
    step();
    recovery_done = 1'b0;
    check_eq({tag, "_done_phase"}, 32'(phase), 32'd0);
    check_eq({tag, "_done_flush_valid"}, 32'(flush_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_al_ptr = '0; req_type = '0; req_pc = '0;
    req_target = '0; al_head_ptr = '0; al_tail_ptr = '0; csr_target = '0;
    recovery_done = 1'b0;
    step(); step();
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_flush_valid", 32'(flush_valid), 32'd0);
    check_eq("rst_refetch_valid", 32'(refetch_valid), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;

    // recovery_done in COMMIT without requests is ignored
    recovery_done = 1'b1;
    step();
    recovery_done = 1'b0;
    check_eq("idle_done_phase", 32'(phase), 32'd0);

    // Branch target on port 0
    al_head_ptr = 6'd10; al_tail_ptr = 6'd30;
    set_req(0, 6'd14, 3'd3, 32'h1000, 32'h2000);
    step();
    req_valid = '0;
    check_eq("t1_phase", 32'(phase), 32'd1);
    check_eq("t1_refetch_pc", refetch_pc, 32'h2000);
    check_eq("t1_flush_head", 32'(flush_head), 32'd15);
    check_eq("t1_flush_tail", 32'(flush_tail), 32'd30);
    check_eq("t1_flush_all", 32'(flush_all), 32'd0);
    check_eq("t1_refetch_valid", 32'(refetch_valid), 32'd1);
    check_eq("t1_flush_valid", 32'(flush_valid), 32'd1);
    check_eq("t1_al_ptr", 32'(recovery_al_ptr), 32'd14);
    step();
    check_eq("t1_r1_phase", 32'(phase), 32'd2);
    check_eq("t1_r1_refetch_valid", 32'(refetch_valid), 32'd0);
    check_eq("t1_r1_flush_valid", 32'(flush_valid), 32'd1);
    check_eq("t1_r1_flush_head", 32'(flush_head), 32'd15);
    recovery_done = 1'b1;
    step();
    recovery_done = 1'b0;
    check_eq("t1_done_phase", 32'(phase), 32'd0);
    check_eq("t1_done_flush_valid", 32'(flush_valid), 32'd0);

    // Age wrap: ptr 62 is age 2, ptr 2 is age 6 relative to head 60
    al_head_ptr = 6'd60; al_tail_ptr = 6'd5;
    set_req(1, 6'd62, 3'd0, 32'h300, 32'h0);
    set_req(2, 6'd2,  3'd0, 32'h400, 32'h0);
    step();
    req_valid = '0;
    check_eq("t2_al_ptr", 32'(recovery_al_ptr), 32'd62);
    check_eq("t2_refetch_pc", refetch_pc, 32'h300);
    check_eq("t2_flush_head", 32'(flush_head), 32'd62);
    check_eq("t2_drop_losers", 32'(drop_count), 32'd0);
    finish_recovery("t2");

    // Tie between ports 0 and 2; NEXT_PC
    al_head_ptr = 6'd0; al_tail_ptr = 6'd40;
    set_req(0, 6'd20, 3'd1, 32'h100, 32'h0);
    set_req(2, 6'd20, 3'd0, 32'h500, 32'h0);
    step();
    req_valid = '0;
    check_eq("t3_refetch_pc", refetch_pc, 32'h104);
    check_eq("t3_flush_head", 32'(flush_head), 32'd21);
    check_eq("t3_al_ptr", 32'(recovery_al_ptr), 32'd20);
    finish_recovery("t3");

    // STORE_NEXT_PC with PC and ptr wrap, accepted in first COMMIT cycle
    set_req(1, 6'd63, 3'd2, 32'hFFFF_FFFC, 32'h0);
    step();
    req_valid = '0;
    check_eq("t3b_refetch_pc", refetch_pc, 32'h0);
    check_eq("t3b_flush_head", 32'(flush_head), 32'd0);
    check_eq("t3b_phase", 32'(phase), 32'd1);
    finish_recovery("t3b");

    // Illegal type 7 acts as THIS_PC
    set_req(2, 6'd9, 3'd7, 32'h700, 32'h900);
    step();
    req_valid = '0;
    check_eq("t3c_refetch_pc", refetch_pc, 32'h700);
    check_eq("t3c_flush_head", 32'(flush_head), 32'd9);
    check_eq("t3c_flush_all", 32'(flush_all), 32'd0);
    finish_recovery("t3c");

    // THIS_PC_TO_CSR, long wait in RECOVER_1, drops while waiting
    csr_target = 32'h80;
    set_req(0, 6'd7, 3'd5, 32'h600, 32'h0);
    step();
    req_valid = '0;
    check_eq("t4_refetch_pc", refetch_pc, 32'h80);
    check_eq("t4_flush_all", 32'(flush_all), 32'd1);
    check_eq("t4_flush_head", 32'(flush_head), 32'd7);
    step();
    for (int i = 0; i < 10; i++) step();
    check_eq("t4_wait_phase", 32'(phase), 32'd2);
    check_eq("t4_wait_flush_valid", 32'(flush_valid), 32'd1);
    req_valid = 3'b111;
    step(); step();
    req_valid = '0;
    check_eq("t5_phase", 32'(phase), 32'd2);
    check_eq("t5_drop", 32'(drop_count), 32'd6);
    check_eq("t5_drop_sat", 32'(drop_count2), 32'd3);
    recovery_done = 1'b1;
    step();
    recovery_done = 1'b0;
    check_eq("t4_done_phase", 32'(phase), 32'd0);
    check_eq("t4_done_flush_all", 32'(flush_all), 32'd0);

    // Reset during RECOVER_1
    set_req(0, 6'd5, 3'd1, 32'h40, 32'h0);
    step();
    req_valid = '0;
    step();
    check_eq("t6_pre_phase", 32'(phase), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("t6_phase", 32'(phase), 32'd0);
    check_eq("t6_flush_valid", 32'(flush_valid), 32'd0);
    check_eq("t6_flush_head", 32'(flush_head), 32'd0);
    check_eq("t6_refetch_pc", refetch_pc, 32'd0);
    check_eq("t6_al_ptr", 32'(recovery_al_ptr), 32'd0);
    check_eq("t6_drop", 32'(drop_count), 32'd0);
    set_req(0, 6'd3, 3'd0, 32'h10, 32'h0);
    step();
    req_valid = '0;
    check_eq("t6_new_phase", 32'(phase), 32'd1);
    check_eq("t6_new_refetch_pc", refetch_pc, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
